// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, defaults and round-robin pick helper for booth_mult_arbiter
package booth_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int MAX_REQ = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;
  // First set bit of valid at or above ptr, wrapping within n entries
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = (ptr + k) % n;
        if (!r.found && valid[j[4:0]]) begin
          r.found = 1'b1;
          r.idx = j[4:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/booth_seq_core.sv
// booth_seq_core: iterative radix-2 Booth datapath, one add/shift step per cycle
module booth_seq_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mc,
  input  logic [WIDTH-1:0]   i_mp,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  // A carries one guard bit so subtracting the most-negative multiplicand cannot overflow
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_sum = ({r_q[0], r_q1} == 2'b01) ? r_a + w_m_ext :
                 ({r_q[0], r_q1} == 2'b10) ? r_a - w_m_ext : r_a;
  assign o_last = (r_count == CW'(WIDTH - 1));
  assign o_prod = {r_a[WIDTH-1:0], r_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_q <= '0;
      r_q1 <= 1'b0;
      r_m <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_a <= '0;
      r_q <= i_mp;
      r_q1 <= 1'b0;
      r_m <= i_mc;
      r_count <= '0;
    end else if (i_step) begin
      r_a <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_q <= {w_sum[0], r_q[WIDTH-1:1]};
      r_q1 <= r_q[0];
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one iterative Booth multiplier among N_REQ requesters
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_mc,
  input  logic [N_REQ*WIDTH-1:0] i_req_mp,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [2*WIDTH-1:0]     o_rsp_prod,
  output logic                   o_busy
);
  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  rr_pick_t        w_pick;
  logic [ID_W-1:0] w_idx;
  logic            w_accept;
  logic            w_last;
  logic [N_REQ-1:0] w_one;
  assign w_one = N_REQ'(1);
  assign w_pick = rr_pick(MAX_REQ'(i_req_valid), 32'(r_ptr), N_REQ);
  assign w_idx = w_pick.idx[ID_W-1:0];
  assign w_accept = (r_state == IDLE) && w_pick.found;
  assign o_req_ready = w_accept ? (w_one << w_idx) : '0;
  assign o_rsp_valid = (r_state == DONE);
  assign o_rsp_id = r_id;
  assign o_busy = (r_state != IDLE);
  booth_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (r_state == RUN),
    .i_mc   (i_req_mc[w_idx*WIDTH +: WIDTH]),
    .i_mp   (i_req_mp[w_idx*WIDTH +: WIDTH]),
    .o_last (w_last),
    .o_prod (o_rsp_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_id <= w_idx;
          r_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
          r_state <= RUN;
        end
        RUN: if (w_last) r_state <= DONE;
        DONE: if (i_rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench; expected products are queued at acceptance and checked on response
module tb_booth_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_mc;
  logic [15:0] req_mp;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        busy;
  typedef struct {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int acc_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_rsp = 0;
  logic [7:0] last_prod;
  logic [1:0] last_id;
  booth_mult_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_mc    (req_mc),
    .i_req_mp    (req_mp),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_prod  (rsp_prod),
    .o_busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{2'(i), 8'($signed(req_mc[i*4 +: 4]) * $signed(req_mp[i*4 +: 4]))});
          acc_q.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else begin
          e_mon = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e_mon.id));
          chk("rsp_prod", 32'(rsp_prod), 32'(e_mon.prod));
        end
        last_prod = rsp_prod;
        last_id = rsp_id;
        n_rsp++;
      end
    end
  end
  task automatic do_req(input int id, input logic [3:0] mc, input logic [3:0] mp);
    int k = 0;
    req_mc[id*4 +: 4] = mc;
    req_mp[id*4 +: 4] = mp;
    req_valid[id] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[id] && k < 200);
    if (!req_ready[id]) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      @(posedge clk);
      #1 k++;
    end
    chk("drain", 32'(sb.size() != 0 || busy), 32'd0);
  endtask
  task automatic wait_rsp();
    int k = 0;
    while (!rsp_valid && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    sb.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  logic [3:0] c_mc[4] = '{4'h8, 4'h8, 4'h0, 4'h3};
  logic [3:0] c_mp[4] = '{4'h8, 4'h7, 4'hB, 4'hE};
  logic [7:0] c_pr[4] = '{8'h40, 8'hC8, 8'h00, 8'hFA};
  int exp_order[5] = '{0, 1, 2, 3, 0};
  initial begin
    int k;
    int rsp_before;
    logic [7:0] hold_prod;
    logic [1:0] hold_id;
    rst_n = 1'b0;
    req_valid = '0;
    req_mc = '0;
    req_mp = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_prod", 32'(rsp_prod), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_dut();
    do_req(2, 4'h3, 4'hE);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("latency", 32'(k), 32'd4);
    chk("single_prod", 32'(rsp_prod), 32'hFA);
    chk("single_id", 32'(rsp_id), 32'd2);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      do_req(0, c_mc[i], c_mp[i]);
      wait_idle();
      chk("corner_prod", 32'(last_prod), 32'(c_pr[i]));
    end
    rsp_before = n_rsp;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        do_req((a + b) % 4, 4'(a), 4'(b));
        wait_idle();
      end
    chk("sweep_count", 32'(n_rsp - rsp_before), 32'd256);
    reset_dut();
    fork
      begin
        do_req(0, 4'h1, 4'h2);
        do_req(0, 4'h3, 4'h3);
      end
      do_req(1, 4'h2, 4'hD);
      do_req(2, 4'h7, 4'h9);
      do_req(3, 4'hC, 4'h5);
    join
    wait_idle();
    chk("rr_count", 32'(acc_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < acc_q.size()) chk("rr_order", 32'(acc_q[i]), 32'(exp_order[i]));
    rsp_ready = 1'b0;
    acc_q.delete();
    do_req(1, 4'h5, 4'hD);
    fork
      do_req(3, 4'h2, 4'h2);
      begin
        wait_rsp();
        hold_prod = rsp_prod;
        hold_id = rsp_id;
        chk("bp_prod", 32'(hold_prod), 32'hF1);
        chk("bp_id", 32'(hold_id), 32'd1);
        repeat (10) begin
          @(negedge clk);
          chk("bp_hold_prod", 32'(rsp_prod), 32'(hold_prod));
          chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
          chk("bp_ready_zero", 32'(req_ready), 32'd0);
          chk("bp_busy", 32'(busy), 32'd1);
          chk("bp_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_grant", 32'(req_ready), 32'h8);
      end
    join
    wait_idle();
    chk("bp_order", 32'(acc_q.size() == 2 && acc_q[1] == 3), 32'd1);
    acc_q.delete();
    do_req(2, 4'h7, 4'h7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_prod", 32'(rsp_prod), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    sb.delete();
    acc_q.delete();
    rsp_before = n_rsp;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("abort_no_rsp", 32'(n_rsp - rsp_before), 32'd0);
    fork
      do_req(3, 4'hF, 4'h3);
      do_req(1, 4'h2, 4'h2);
    join
    wait_idle();
    chk("post_rst_order", 32'(acc_q.size() == 2 && acc_q[0] == 1 && acc_q[1] == 3), 32'd1);
    rsp_ready = 1'b0;
    acc_q.delete();
    do_req(0, 4'h3, 4'h3);
    fork
      do_req(3, 4'hE, 4'h5);
      begin
        req_mc[7:4] = 4'h4;
        req_mp[7:4] = 4'h4;
        req_valid[1] = 1'b1;
        wait_rsp();
        repeat (2) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_idle();
    chk("drop_order", 32'(acc_q.size() == 2 && acc_q[1] == 3), 32'd1);
    chk("drop_last_id", 32'(last_id), 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin scheduler that shares one iterative radix-2 Booth multiplier core between `N_REQ` requesters. It accepts one signed multiply request at a time over a valid/ready handshake and sequences the core through load and `WIDTH` shift steps. It returns the product with the winning requester's index on a single response channel. The block sits between the DSP-side clients and the shared multiplier datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 4, operand width in bits; product is `2*WIDTH`
- `ID_W`, `$clog2(N_REQ)`, width of requester index

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — asynchronous active-low reset
- `req_valid` in `N_REQ` — per-requester request valid
- `req_mc` in `N_REQ*WIDTH` — packed signed multiplicands; requester i at `[i*WIDTH +: WIDTH]`
- `req_mp` in `N_REQ*WIDTH` — packed signed multipliers, same packing
- `req_ready` out `N_REQ` — one-hot grant/accept; at most one bit set
- `rsp_valid` out 1 — product available
- `rsp_ready` in 1 — consumer accepts product
- `rsp_id` out `ID_W` — index of requester that owns `rsp_prod`
- `rsp_prod` out `2*WIDTH` — signed product `mc*mp`
- `busy` out 1 — high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready` is combinational. Grant goes to the first requester with `req_valid` set, searching upward from `rr_ptr` with wrap.
  - On handshake (`req_valid[i] & req_ready[i]`):
    - Capture `M=mc`, `Q=mp`, `A=0`, `Q_1=0`, `count=0`, `id=i`.
    - Set `rr_ptr = (i+1) mod N_REQ`.
    - Go to RUN.
- RUN: one Booth step per cycle on `{Q[0],Q_1}`:
  - 01: A+=M
  - 10: A-=M
  - else: no add
  - Then arithmetic right shift of `{A,Q,Q_1}`.
  - `count` increments each step; after step `WIDTH`, go to DONE.
- DONE:
  - `rsp_valid=1`, `rsp_prod = low 2*WIDTH bits of {A,Q}`, `rsp_id=id`.
  - Outputs are held stable until `rsp_ready`, then go to IDLE.
- Arithmetic: `A` is `WIDTH+1` bits, so the most-negative multiplicand does not overflow. Operands and product are two's complement.
- `req_ready` is all-zero outside IDLE. Requesters must hold `req_valid` and operands stable until accepted; a dropped request is simply not granted.
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_prod=0`, `rsp_id=0`, `busy=0`
  - state IDLE, `rr_ptr=0`
- Reset mid-operation aborts the operation. No response is issued; the interrupted requester must re-request.

## Timing
- Accept at edge E0. Booth steps occur at edges E1..E`WIDTH`.
- `rsp_valid` is high in the cycle after edge E`WIDTH`, i.e. `WIDTH` cycles after the acceptance cycle (4 for default).
- `rsp_ready` high in the first DONE cycle gives IDLE on the next edge. Minimum request-to-request spacing is `WIDTH+2` cycles.
- No new grant in the cycle the response is consumed; the grant occurs in the following IDLE cycle.
- Simultaneous requests: exactly one grant. The pointer guarantees each continuously-requesting client a grant within `N_REQ` operations.
- Backpressure: DONE may last indefinitely; `busy` stays high and no requester is granted.

## Structure
- Shared package `booth_pkg`: state enum (IDLE/RUN/DONE), default `WIDTH`, and a function for the round-robin pick (`rr_ptr`, valid vector → index/found).
- Sub-module `booth_seq_core`:
  - Contains the `A/Q/Q_1/M/count` datapath with `load`, `step`, `last` and `prod` ports, plus its add/subtract unit.
  - The top holds the FSM, arbiter pointer and response registers.

## Test plan
- Single request: requester 2 sends `mc=3`, `mp=-2` → `rsp_prod=8'hFA` (-6), `rsp_id=2`, `rsp_valid` exactly 4 cycles after accept.
- Corner operands:
  - `-8*-8` → `8'h40`
  - `-8*7` → `8'hC8`
  - `0*-5` → `8'h00`
  - Exhaustive 256-pair sweep matches `$signed` reference.
- All four requesters valid from reset → grant order 0,1,2,3,0; each `rsp_id` matches its operands.
- `rsp_ready` held low 10 cycles in DONE → `rsp_prod`/`rsp_id` stable, `req_ready` all-zero, `busy=1`; release → IDLE next edge.
- Assert `rst_n` low during RUN step 2 → outputs reset immediately, no `rsp_valid`; after release, a fresh request completes normally with `rr_ptr=0` ordering.
- Requester 1 drops valid before grant while 3 is pending → grant goes to 3, no response ever tagged 1.
